rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
Reset sequencer that turns one raw reset into NUM_DOMAINS ordered, clock-synchronous reset outputs.
- Resets release one at a time, low index first, with a fixed spacing between releases.
- Accepts a synchronous software reset request that re-runs the sequence.
- Sits at the top of each clock domain, between the pin-level reset and the downstream blocks.

Parameters:
- NUM_DOMAINS, 4: number of sequenced reset outputs; must be ≥1.
- STAGE_DELAY, 16: clock cycles between consecutive domain releases; must be ≥1.
- SW_RST_HOLD, 8: cycles all domains are held in reset after a software request; must be ≥1.
- SYNC_STAGES, 2: flop depth of the internal reset synchronizer; must be ≥2.

Ports:
- clk  input  1  block clock.
- rst  input  1  asynchronous, active-high reset.
- sw_rst_req  input  1  synchronous software reset request; level-sensitive.
- dom_rst  output  NUM_DOMAINS  per-domain reset, active-high; bit k feeds domain k.
- rst_done  output  1  high once every domain is released.
- busy  output  1  equals ~rst_done.

Behaviour:
- Reset values (rst high): dom_rst = all ones, rst_done = 0, busy = 1, FSM in RESET, counters 0.
  - All outputs are asynchronously forced to these values the moment rst asserts, in any state.
- Internal reset: rst passes through an assert-async / deassert-sync synchronizer SYNC_STAGES deep.
  - E0 is the SYNC_STAGES-th rising clk edge after rst falls; the FSM leaves RESET at E0.
- FSM states:
  - RESET → RELEASE at E0.
  - RELEASE:
    - Delay counter cnt and domain index idx both start at 0.
    - When cnt reaches STAGE_DELAY-1, dom_rst[idx] is cleared, cnt returns to 0, and idx increments.
    - dom_rst[k] falls at edge E0 + (k+1)*STAGE_DELAY.
    - Released bits stay low. Bits are never released out of order.
    - After the last domain is released → DONE_WAIT.
  - DONE_WAIT: one cycle; rst_done rises at E0 + NUM_DOMAINS*STAGE_DELAY + 1 → RUN.
  - RUN: holds outputs. sw_rst_req sampled high at an edge → at that same edge dom_rst = all ones, rst_done = 0 → HOLD.
  - HOLD: held for SW_RST_HOLD cycles → RELEASE. Edge numbering then restarts, with E0 taken as the edge of the HOLD→RELEASE transition.
- sw_rst_req rules:
  - Ignored outside RUN. Not queued.
  - If still high on the first RUN cycle after a sequence, a new sequence starts at that edge.
- Async rst during RELEASE, HOLD or DONE_WAIT: immediate return to the reset values; the full sequence restarts from the new E0.
- Glitch-free outputs: every dom_rst bit is a direct flop output with an async preset. There is no combinational logic after the flops.
- Counter width: clog2(max(STAGE_DELAY, SW_RST_HOLD)), minimum 1. idx width: clog2(NUM_DOMAINS), minimum 1. No wrap beyond the terminal counts.

Decomposition:
- Shared package (rst_seq_pkg):
  - FSM state enum: RESET, RELEASE, DONE_WAIT, RUN, HOLD.
  - Width helper function for the counter and idx widths.
- One sub-module, rst_sync_stage: the SYNC_STAGES-deep async-assert / sync-deassert synchronizer, ports clk, rst, sync_rst. Instantiated once.

Test Plan:
All scenarios use defaults and a 20 ns clk.
1. Power-on: rst high for 3 cycles, then low.
   → dom_rst = 4'b1111 until E0+16.
   → Then 4'b1110 at E0+16, 4'b1100 at E0+32, 4'b1000 at E0+48, 4'b0000 at E0+64.
   → rst_done rises at E0+65; busy is its complement throughout.
2. In RUN, pulse sw_rst_req high for 1 cycle at edge T.
   → dom_rst = 4'b1111 and rst_done = 0 from T.
   → HOLD lasts 8 cycles; releases follow at 16-cycle spacing as in scenario 1, rst_done at new E0+65.
3. Assert rst asynchronously mid-RELEASE, at E0+40 (dom_rst = 4'b1100).
   → dom_rst = 4'b1111 within the same cycle, before the next edge; rst_done = 0.
   → After rst falls, the full sequence repeats from the new E0.
4. Drive sw_rst_req high during RELEASE and HOLD, low before RUN.
   → No effect on the timing of scenario 1/2; no extra sequence afterwards.
5. Hold sw_rst_req high continuously.
   → Sequence repeats back-to-back; rst_done is high for exactly one cycle each time.
   → Release spacing stays 16 cycles.
6. Rebuild with NUM_DOMAINS=1, STAGE_DELAY=1, SW_RST_HOLD=1.
   → dom_rst falls at E0+1; rst_done rises at E0+2.
   → A software request in RUN gives a 1-cycle hold, then release 1 cycle later.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   seq_state_e : sequencer FSM states
//   width_of()  : bit width needed to count 0..n-1 (never less than 1)
package rst_seq_pkg;

  typedef enum logic [2:0] {
    StReset,
    StRelease,
    StDoneWait,
    StRun,
    StHold
  } seq_state_e;

  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rst_sync_stage.sv
// Reset synchronizer: asserts asynchronously with rst and deasserts on the
// SYNC_STAGES-th rising clk edge after rst falls.
//   clk      : block clock
//   rst      : raw asynchronous active-high reset
//   sync_rst : synchronized active-high reset
module rst_sync_stage #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sync_rst
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign sync_rst = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: turns one raw reset into NUM_DOMAINS ordered resets that
// release low index first, STAGE_DELAY cycles apart. A software request in RUN
// holds every domain for SW_RST_HOLD cycles and re-runs the sequence.
//   clk        : block clock
//   rst        : asynchronous active-high reset
//   sw_rst_req : synchronous level-sensitive software reset request
//   dom_rst    : per-domain active-high reset, bit k feeds domain k
//   rst_done   : high once every domain is released
//   busy       : complement of rst_done
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned STAGE_DELAY = 16,
  parameter int unsigned SW_RST_HOLD = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   rst_done,
  output logic                   busy
);

  localparam int unsigned CntMax = (STAGE_DELAY > SW_RST_HOLD) ? STAGE_DELAY : SW_RST_HOLD;
  localparam int unsigned CntW   = width_of(CntMax);
  localparam int unsigned IdxW   = width_of(NUM_DOMAINS);

  localparam logic [CntW-1:0] StageLast = CntW'(STAGE_DELAY - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(SW_RST_HOLD - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DOMAINS - 1);

  logic sync_rst;

  rst_sync_stage #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk     (clk),
    .rst     (rst),
    .sync_rst(sync_rst)
  );

  seq_state_e             state_q;
  logic [CntW-1:0]        cnt_q;
  logic [IdxW-1:0]        idx_q;
  logic [NUM_DOMAINS-1:0] dom_rst_q;
  logic                   rst_done_q;
  logic                   busy_q;

  // sync_rst asserts together with rst, so every output flop is preset the
  // moment rst rises. sync_rst drops at E0; the cycle following E0 is already
  // counted as the first release cycle, so StReset shares the release step.
  always_ff @(posedge clk or posedge sync_rst) begin
    if (sync_rst) begin
      state_q    <= StReset;
      cnt_q      <= '0;
      idx_q      <= '0;
      dom_rst_q  <= '1;
      rst_done_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      unique case (state_q)
        StReset, StRelease: begin
          if (cnt_q == StageLast) begin
            cnt_q     <= '0;
            // Domains release in index order, so shifting in a zero clears
            // exactly bit idx_q.
            dom_rst_q <= dom_rst_q << 1;
            if (idx_q == IdxLast) begin
              idx_q   <= '0;
              state_q <= StDoneWait;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StRelease;
            end
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= StRelease;
          end
        end
        StDoneWait: begin
          rst_done_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= StRun;
        end
        StRun: begin
          if (sw_rst_req) begin
            dom_rst_q  <= '1;
            rst_done_q <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            idx_q      <= '0;
            state_q    <= StHold;
          end
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            cnt_q   <= '0;
            state_q <= StRelease;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StReset;
      endcase
    end
  end

  assign dom_rst  = dom_rst_q;
  assign rst_done = rst_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: a scoreboard of expected output
// changes (edge number + value) is filled when stimulus is driven and drained
// by a negedge monitor; a second instance covers the minimal configuration.
module tb_rst_seq_ctrl;

  typedef struct {
    int unsigned edge_n;
    logic [3:0]  dom;
    logic        done;
  } ev_t;

  // Expected dom_rst after domain k releases.
  localparam logic [3:0] Pat0 = 4'b1110;
  localparam logic [3:0] Pat1 = 4'b1100;
  localparam logic [3:0] Pat2 = 4'b1000;
  localparam logic [3:0] Pat3 = 4'b0000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [3:0] dom_rst;
  logic       rst_done;
  logic       busy;

  logic       rst_s = 1'b0;
  logic       sw_s = 1'b0;
  logic [0:0] dom_s;
  logic       done_s;
  logic       busy_s;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         sb_q[$];
  logic        mon_en = 1'b0;
  logic [4:0]  prev_obs;
  logic [4:0]  mon_obs;
  ev_t         mon_ev;

  rst_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .sw_rst_req(sw_rst_req),
    .dom_rst   (dom_rst),
    .rst_done  (rst_done),
    .busy      (busy)
  );

  rst_seq_ctrl #(
    .NUM_DOMAINS(1),
    .STAGE_DELAY(1),
    .SW_RST_HOLD(1),
    .SYNC_STAGES(2)
  ) dut_s (
    .clk       (clk),
    .rst       (rst_s),
    .sw_rst_req(sw_s),
    .dom_rst   (dom_s),
    .rst_done  (done_s),
    .busy      (busy_s)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every change of {dom_rst, rst_done} must match the
  // next expected event in both value and edge number.
  always @(negedge clk) begin
    mon_obs = {dom_rst, rst_done};
    if (mon_en) begin
      checks++;
      if (busy !== ~rst_done) begin
        errors++;
        $display("FAIL busy_compl @%0d: busy=%b rst_done=%b", cyc, busy, rst_done);
      end
      if (mon_obs !== prev_obs) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change @%0d: got %b/%b, no change expected", cyc,
                   dom_rst, rst_done);
        end else begin
          mon_ev = sb_q.pop_front();
          if (mon_ev.edge_n != cyc || {mon_ev.dom, mon_ev.done} !== mon_obs) begin
            errors++;
            $display("FAIL seq_event: got %b/%b at edge %0d, expected %b/%b at edge %0d",
                     dom_rst, rst_done, cyc, mon_ev.dom, mon_ev.done, mon_ev.edge_n);
          end
        end
      end
    end
    prev_obs = mon_obs;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_ev(input int unsigned e, input logic [3:0] d, input logic dn);
    ev_t ev;
    ev.edge_n = e;
    ev.dom    = d;
    ev.done   = dn;
    sb_q.push_back(ev);
  endtask

  task automatic push_seq(input int unsigned e0);
    push_ev(e0 + 16, Pat0, 1'b0);
    push_ev(e0 + 32, Pat1, 1'b0);
    push_ev(e0 + 48, Pat2, 1'b0);
    push_ev(e0 + 64, Pat3, 1'b0);
    push_ev(e0 + 65, 4'b0000, 1'b1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick(1);
    tick(1);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d events outstanding, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    rst_s = 1'b1;
    tick(3);
    checks++;
    if (dom_rst !== 4'b1111 || rst_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_vals: got %b/%b/%b expected 1111/0/1", dom_rst, rst_done, busy);
    end
  endtask

  task automatic test_power_on();
    push_seq(cyc + 2);
    rst    = 1'b0;
    mon_en = 1'b1;
    wait_drain("power_on", 120);
  endtask

  task automatic test_sw_req();
    int unsigned t;
    t = cyc + 1;
    push_ev(t, 4'b1111, 1'b0);
    push_seq(t + 8);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    checks++;
    if (dom_rst !== 4'b1111 || rst_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sw_req_assert: got %b/%b/%b expected 1111/0/1", dom_rst, rst_done, busy);
    end
    wait_drain("sw_req", 120);
  endtask

  task automatic test_async_rst();
    int unsigned t;
    int unsigned e0;
    t  = cyc + 1;
    e0 = t + 8;
    push_ev(t, 4'b1111, 1'b0);
    push_ev(e0 + 16, Pat0, 1'b0);
    push_ev(e0 + 32, Pat1, 1'b0);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    while (cyc < e0 + 40) tick(1);
    checks++;
    if (dom_rst !== 4'b1100 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL mid_release: got %b (%0d pending) expected 1100 (0 pending)", dom_rst,
               sb_q.size());
    end
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    checks++;
    if (dom_rst !== 4'b1111 || rst_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_assert: got %b/%b/%b expected 1111/0/1", dom_rst, rst_done, busy);
    end
    tick(2);
    push_seq(cyc + 2);
    rst    = 1'b0;
    mon_en = 1'b1;
    wait_drain("async_rst", 120);
  endtask

  task automatic test_ignored_req();
    int unsigned t;
    t = cyc + 1;
    push_ev(t, 4'b1111, 1'b0);
    push_seq(t + 8);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    tick(3);
    sw_rst_req = 1'b1;
    while (cyc < t + 8 + 30) tick(1);
    sw_rst_req = 1'b0;
    wait_drain("ignored_req", 120);
    tick(20);
    checks++;
    if (dom_rst !== 4'b0000 || rst_done !== 1'b1) begin
      errors++;
      $display("FAIL no_extra_seq: got %b/%b expected 0000/1", dom_rst, rst_done);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned t1;
    int unsigned t2;
    t1 = cyc + 1;
    t2 = t1 + 74;
    push_ev(t1, 4'b1111, 1'b0);
    push_seq(t1 + 8);
    push_ev(t2, 4'b1111, 1'b0);
    push_seq(t2 + 8);
    sw_rst_req = 1'b1;
    while (cyc < t2 + 72) tick(1);
    sw_rst_req = 1'b0;
    wait_drain("back_to_back", 40);
    tick(10);
    checks++;
    if (rst_done !== 1'b1 || dom_rst !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_settle: got %b/%b expected 0000/1", dom_rst, rst_done);
    end
  endtask

  task automatic test_small_cfg();
    int unsigned e0;
    e0    = cyc + 2;
    rst_s = 1'b0;
    while (cyc < e0) tick(1);
    checks++;
    if (dom_s !== 1'b1 || done_s !== 1'b0 || busy_s !== 1'b1) begin
      errors++;
      $display("FAIL small_e0: got %b/%b/%b expected 1/0/1", dom_s, done_s, busy_s);
    end
    tick(1);
    checks++;
    if (dom_s !== 1'b0 || done_s !== 1'b0) begin
      errors++;
      $display("FAIL small_release: got %b/%b expected 0/0", dom_s, done_s);
    end
    tick(1);
    checks++;
    if (done_s !== 1'b1 || busy_s !== 1'b0) begin
      errors++;
      $display("FAIL small_done: got %b/%b expected 1/0", done_s, busy_s);
    end
    sw_s = 1'b1;
    tick(1);
    sw_s = 1'b0;
    checks++;
    if (dom_s !== 1'b1 || done_s !== 1'b0) begin
      errors++;
      $display("FAIL small_sw_assert: got %b/%b expected 1/0", dom_s, done_s);
    end
    tick(1);
    checks++;
    if (dom_s !== 1'b1) begin
      errors++;
      $display("FAIL small_hold_end: got %b expected 1", dom_s);
    end
    tick(1);
    checks++;
    if (dom_s !== 1'b0 || done_s !== 1'b0) begin
      errors++;
      $display("FAIL small_sw_release: got %b/%b expected 0/0", dom_s, done_s);
    end
    tick(1);
    checks++;
    if (done_s !== 1'b1 || busy_s !== 1'b0) begin
      errors++;
      $display("FAIL small_sw_done: got %b/%b expected 1/0", done_s, busy_s);
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_sw_req();
    test_async_rst();
    test_ignored_req();
    test_back_to_back();
    test_small_cfg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
